// File: rtl/wb_master_pkg.sv
// ----------------------------------------------------------------------------
// wb_master_pkg
// Shared definitions for the single-outstanding Wishbone classic initiator:
//   - default bus widths used by the northbridge responders
//   - state encoding of the master FSM (IDLE / BUS / RSP)
//   - timer_width(): smallest counter width able to hold a TIMEOUT value
// ----------------------------------------------------------------------------
package wb_master_pkg;

    localparam int unsigned DEF_ADR_W = 36;
    localparam int unsigned DEF_DAT_W = 32;

    // Master FSM states, kept as plain constants for older tool flows.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUS  = 2'd1;
    localparam state_t ST_RSP  = 2'd2;

    // Minimum number of bits needed to represent 'timeout' (at least 1).
    function automatic int unsigned timer_width(input int unsigned timeout);
        int unsigned w;
        w = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd32; i++) begin
            if ((64'd1 << i) <= 64'(timeout)) begin
                w = i + 32'd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_master_timer.sv
// ----------------------------------------------------------------------------
// wb_master_timer
// Saturating strobe-age counter for the Wishbone master.
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   clear_i    force the count back to zero (has priority over enable_i)
//   enable_i   advance the count by one this cycle
//   expired_o  high while the count equals TIMEOUT-1
// With TIMEOUT = 0 the counter never advances and expired_o stays low.
// ----------------------------------------------------------------------------
module wb_master_timer
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned TW = timer_width(TIMEOUT);
    localparam logic        TO_ON = (TIMEOUT != 32'd0);
    // TIMEOUT-1 only matters when the timer is enabled, so zero is safe otherwise.
    localparam logic [TW-1:0] LAST = TO_ON ? TW'(TIMEOUT - 32'd1) : {TW{1'b0}};
    localparam logic [TW-1:0] SAT  = TW'(TIMEOUT);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear wins, then a saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {TW{1'b0}};
        end else if (enable_i && TO_ON && (count_q != SAT)) begin
            count_d = count_q + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {TW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = TO_ON && (count_q == LAST);

endmodule

// File: rtl/wb_simple_master.sv
// ----------------------------------------------------------------------------
// wb_simple_master
// Single-outstanding Wishbone classic-cycle initiator. One command in, one
// bus cycle out, one response back; no overlap between them.
//   clk, rst                    clock and synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_we/adr/dat/sel          command payload
//   rsp_valid/rsp_ready         response handshake
//   rsp_dat/rsp_err             read data (0 for writes/errors), timeout flag
//   wb_*                        Wishbone classic initiator port
// All bus and response outputs come straight from registers.
// ----------------------------------------------------------------------------
module wb_simple_master
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADR_W   = DEF_ADR_W,
    parameter int unsigned DAT_W   = DEF_DAT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [DAT_W-1:0]   cmd_dat,
    input  logic [DAT_W/8-1:0] cmd_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic               rsp_err,
    output logic [ADR_W-1:0]   wb_adr_o,
    output logic [DAT_W-1:0]   wb_dat_o,
    input  logic [DAT_W-1:0]   wb_dat_i,
    output logic               wb_we_o,
    output logic [DAT_W/8-1:0] wb_sel_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o,
    input  logic               wb_ack_i
);

    localparam int unsigned SEL_W = DAT_W / 8;

    state_t             state_q,     state_d;
    logic               bus_q,       bus_d;      // drives both cyc and stb
    logic               we_q,        we_d;
    logic [ADR_W-1:0]   adr_q,       adr_d;
    logic [DAT_W-1:0]   dat_q,       dat_d;
    logic [SEL_W-1:0]   sel_q,       sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_q,   rsp_dat_d;
    logic               rsp_err_q,   rsp_err_d;

    logic               timer_expired;
    logic               timer_clear;
    logic               timer_enable;

    // The timer only runs while a strobe is outstanding; any other state rearms it.
    assign timer_clear  = (state_q != ST_BUS);
    assign timer_enable = (state_q == ST_BUS);

    wb_master_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    // FSM next-state and output-register next values.
    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                // cmd_ready is high in IDLE, so cmd_valid alone is the accept.
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    bus_d   = 1'b1;
                    state_d = ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                // Ack is checked first so an ack on the expiry cycle is a success.
                if (wb_ack_i) begin
                    bus_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = we_q ? {DAT_W{1'b0}} : wb_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else if (timer_expired) begin
                    bus_d       = 1'b0;
                    rsp_dat_d   = {DAT_W{1'b0}};
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RSP: begin
                // rsp_dat/rsp_err deliberately keep their values after the handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                bus_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= {ADR_W{1'b0}};
            dat_q       <= {DAT_W{1'b0}};
            sel_q       <= {SEL_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= {DAT_W{1'b0}};
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign wb_cyc_o  = bus_q;
    assign wb_stb_o  = bus_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_simple_master.sv
// ----------------------------------------------------------------------------
// tb_wb_simple_master
// Self-checking bench: a transaction-level reference model predicts every
// DUT output each cycle; directed scenarios add literal expectations; a
// randomized phase exercises random commands, responders and backpressure.
// ----------------------------------------------------------------------------
module tb_wb_simple_master;

    localparam int unsigned TO = 4;
    localparam int unsigned AW = 36;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_dat;
    logic [SW-1:0] cmd_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_we_o;
    logic [SW-1:0] wb_sel_o;
    logic          wb_stb_o;
    logic          wb_cyc_o;
    logic          wb_ack_i;

    always #5 clk = ~clk;

    wb_simple_master #(.TIMEOUT(TO), .ADR_W(AW), .DAT_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction rules) ----------------
    logic          m_ok = 1'b0;
    logic          m_cyc, m_we, m_rv, m_err;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat, m_rdat;
    logic [SW-1:0] m_sel;
    int            m_age;

    always @(posedge clk) begin
        if (rst) begin
            m_ok <= 1'b1; m_cyc <= 1'b0; m_we <= 1'b0; m_rv <= 1'b0; m_err <= 1'b0;
            m_adr <= '0; m_dat <= '0; m_sel <= '0; m_rdat <= '0; m_age <= 0;
        end else if (m_ok) begin
            if (m_cyc) begin
                if (wb_ack_i) begin
                    m_cyc <= 1'b0; m_we <= 1'b0; m_err <= 1'b0; m_rv <= 1'b1;
                    m_rdat <= m_we ? 32'h0 : wb_dat_i;
                end else if (m_age == int'(TO) - 1) begin
                    m_cyc <= 1'b0; m_err <= 1'b1; m_rv <= 1'b1; m_rdat <= 32'h0;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (m_rv) begin
                if (rsp_ready) m_rv <= 1'b0;
            end else if (cmd_valid) begin
                m_cyc <= 1'b1; m_we <= cmd_we; m_adr <= cmd_adr; m_dat <= cmd_dat;
                m_sel <= cmd_sel; m_age <= 0;
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("cmd_ready", 64'(cmd_ready), 64'(!m_cyc && !m_rv));
            chk("wb_cyc",    64'(wb_cyc_o),  64'(m_cyc));
            chk("wb_stb",    64'(wb_stb_o),  64'(m_cyc));
            chk("wb_we",     64'(wb_we_o),   64'(m_we));
            chk("wb_adr",    64'(wb_adr_o),  64'(m_adr));
            chk("wb_dat",    64'(wb_dat_o),  64'(m_dat));
            chk("wb_sel",    64'(wb_sel_o),  64'(m_sel));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
            chk("rsp_dat",   64'(rsp_dat),   64'(m_rdat));
            chk("rsp_err",   64'(rsp_err),   64'(m_err));
        end
    end

    // ---------------- responder ----------------
    // mode: 0 silent, 1 registered-ack memory, 2 ack on 4th strobe cycle,
    //       3 ack stuck high, 4 random ack
    int            mode = 1;
    logic          prev_stb;
    int            stb_run;
    logic          ack_n;
    logic [DW-1:0] mem [16];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        wb_ack_i = 1'b0; wb_dat_i = 32'h0; prev_stb = 1'b0; stb_run = 0;
        forever begin
            @(posedge clk); #1;
            case (mode)
                1: begin
                    ack_n = prev_stb && !wb_ack_i;
                    wb_dat_i = $urandom;
                    if (ack_n && wb_we_o) begin
                        for (int b = 0; b < int'(SW); b++)
                            if (wb_sel_o[b]) mem[wb_adr_o[3:0]][8*b +: 8] = wb_dat_o[8*b +: 8];
                    end else if (ack_n) begin
                        wb_dat_i = mem[wb_adr_o[3:0]];
                    end
                    wb_ack_i = ack_n;
                end
                2: begin
                    if (wb_stb_o) stb_run = stb_run + 1;
                    else stb_run = 0;
                    wb_ack_i = wb_stb_o && (stb_run == 4);
                    wb_dat_i = 32'h12345678;
                end
                3: begin wb_ack_i = 1'b1; wb_dat_i = $urandom; end
                4: begin wb_ack_i = wb_stb_o && ($urandom_range(0, 2) == 0); wb_dat_i = $urandom; end
                default: begin wb_ack_i = 1'b0; wb_dat_i = 32'h0; end
            endcase
            prev_stb = wb_stb_o;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_cmd(input logic we, input logic [AW-1:0] adr,
                             input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        int k;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 1000) begin tick(); k++; end
        if (k >= 1000) chk("cmd_ready_wait_bound", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called in the cycle after accept; lat counts cycles from accept to rsp_valid.
    task automatic wait_rsp(output int lat, output int stbs);
        lat = 1; stbs = 0;
        while (!rsp_valid && lat < 600) begin
            if (wb_stb_o) stbs++;
            tick(); lat++;
        end
        if (!rsp_valid) chk("rsp_wait_bound", 64'(rsp_valid), 64'd1);
    endtask

    task automatic finish_rsp(input int delay);
        rsp_ready = 1'b0;
        repeat (delay) tick();
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    endtask

    int lat, stbs;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_cyc",       64'(wb_cyc_o),  64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_adr",       64'(wb_adr_o),  64'd0);
        chk("rst_rsp_dat",   64'(rsp_dat),   64'd0);

        // write then read back
        mode = 1;
        start_cmd(1'b1, 36'h1, 32'hDEADBEEF, 4'hF);
        wait_rsp(lat, stbs);
        chk("wr_latency", 64'(lat), 64'd3);
        chk("wr_cyc_at_rsp", 64'(wb_cyc_o), 64'd0);
        chk("wr_err", 64'(rsp_err), 64'd0);
        chk("wr_dat", 64'(rsp_dat), 64'd0);
        finish_rsp(0);
        start_cmd(1'b0, 36'h1, 32'h0, 4'hF);
        wait_rsp(lat, stbs);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_dat", 64'(rsp_dat), 64'hDEADBEEF);
        chk("rd_err", 64'(rsp_err), 64'd0);
        finish_rsp(1);

        // no responder: timeout
        mode = 0;
        start_cmd(1'b0, 36'h5, 32'h0, 4'hF);
        wait_rsp(lat, stbs);
        chk("to_stb_cycles", 64'(stbs), 64'd4);
        chk("to_err", 64'(rsp_err), 64'd1);
        chk("to_dat", 64'(rsp_dat), 64'd0);
        chk("to_cyc", 64'(wb_cyc_o), 64'd0);
        finish_rsp(0);

        // ack on the expiry cycle
        mode = 2;
        start_cmd(1'b0, 36'h7, 32'h0, 4'hF);
        wait_rsp(lat, stbs);
        chk("exp_ack_stbs", 64'(stbs), 64'd4);
        chk("exp_ack_err", 64'(rsp_err), 64'd0);
        chk("exp_ack_dat", 64'(rsp_dat), 64'h12345678);
        finish_rsp(0);

        // backpressure with a waiting command
        mode = 1;
        start_cmd(1'b1, 36'h2, 32'hAAAA5555, 4'h3);
        wait_rsp(lat, stbs);
        cmd_we = 1'b0; cmd_adr = 36'h2; cmd_dat = 32'h0; cmd_sel = 4'hF; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_dat",   64'(rsp_dat),   64'd0);
            chk("bp_rsp_err",   64'(rsp_err),   64'd0);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("bp_ready_after", 64'(cmd_ready), 64'd1);
        chk("bp_valid_after", 64'(rsp_valid), 64'd0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_accept_cyc", 64'(wb_cyc_o), 64'd1);
        chk("bp_accept_adr", 64'(wb_adr_o), 64'h2);
        wait_rsp(lat, stbs);
        chk("bp_rd_latency", 64'(lat), 64'd3);
        chk("bp_rd_dat_sel", 64'(rsp_dat), 64'h00005555);
        finish_rsp(0);

        // reset in the middle of a bus cycle, then stray acks while idle
        mode = 0;
        start_cmd(1'b0, 36'h3, 32'h0, 4'hF);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_cyc", 64'(wb_cyc_o), 64'd0);
        chk("mid_rst_stb", 64'(wb_stb_o), 64'd0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        mode = 3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("stray_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("stray_cyc", 64'(wb_cyc_o), 64'd0);
        end
        mode = 0;
        tick();

        // randomized traffic checked by the model
        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            mode = (r < 5) ? 1 : ((r < 9) ? 4 : 0);
            repeat ($urandom_range(0, 2)) tick();
            start_cmd(1'($urandom), {32'h0, 4'($urandom)}, $urandom, 4'($urandom));
            wait_rsp(lat, stbs);
            cmd_valid = 1'($urandom);
            cmd_we = 1'($urandom); cmd_adr = {32'h0, 4'($urandom)};
            cmd_dat = $urandom; cmd_sel = 4'($urandom);
            finish_rsp(int'($urandom_range(0, 3)));
            cmd_valid = 1'b0;
            if (wb_cyc_o) begin
                wait_rsp(lat, stbs);
                finish_rsp(0);
            end
        end

        mode = 0;
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
